// File: rtl/gowin_ddr.sv
// 7:1 parallel-to-serial gearbox: captures a 49-bit time-slot-major frame on
// each load edge and emits one 7-lane slot per i_clk_fast cycle, slot 0 first.
module gowin_ddr #(
  parameter int unsigned LANES = 7,
  parameter int unsigned RATIO = 7
) (
  input  logic                   i_clk_fast,
  input  logic                   i_resetn,
  input  logic [LANES*RATIO-1:0] din,
  output logic                   o_load,
  output logic [LANES-1:0]       o_q
);

  localparam int unsigned CntW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RATIO - 1);

  logic [CntW-1:0]          r_cnt;
  logic [LANES*RATIO-1:0]   r_hold;
  logic [LANES-1:0]         r_q;
  logic [CntW-1:0]          w_next_slot;
  logic [LANES-1:0]         w_slot_bits;
  logic                     w_load;

  // Frame boundary: the edge that ends the last slot also samples din.
  always_comb begin
    w_load      = (r_cnt == CntLast);
    w_next_slot = r_cnt + CntW'(1);
  end

  // Select the next slot's lane bits out of the held frame.
  always_comb begin
    w_slot_bits = '0;
    for (int unsigned t = 0; t < RATIO; t++) begin
      if (w_next_slot == CntW'(t)) begin
        w_slot_bits = r_hold[t*LANES +: LANES];
      end
    end
  end

  // Slot counter, holding register and output register; slot 0 bypasses hold
  // so a new frame starts the cycle right after the previous one ends.
  always_ff @(posedge i_clk_fast or negedge i_resetn) begin
    if (!i_resetn) begin
      r_cnt  <= CntLast;
      r_hold <= '0;
      r_q    <= '0;
    end else if (w_load) begin
      r_cnt  <= '0;
      r_hold <= din;
      r_q    <= din[LANES-1:0];
    end else begin
      r_cnt  <= w_next_slot;
      r_q    <= w_slot_bits;
    end
  end

  // Outputs.
  always_comb begin
    o_load = w_load;
    o_q    = r_q;
  end

endmodule

// File: tb/tb_gowin_ddr.sv
// Directed self-checking bench for the gowin_ddr 7:1 gearbox.
module tb_gowin_ddr;

  logic        clk;
  logic        resetn;
  logic [48:0] din;
  logic        load;
  logic [6:0]  q;

  int n_checks = 0;
  int n_errors = 0;

  gowin_ddr dut (
    .i_clk_fast (clk),
    .i_resetn   (resetn),
    .din        (din),
    .o_load     (load),
    .o_q        (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two clocks with din preset, release on a falling edge so the
  // next rising edge is the first load edge.
  task automatic align(input logic [48:0] d);
    @(negedge clk);
    resetn = 1'b0;
    din    = d;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    din    = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (q !== 7'h00) begin
        n_errors++;
        $display("FAIL reset_q cyc %0d: got %h want 00", i, q);
      end
      n_checks++;
      if (load !== 1'b1) begin
        n_errors++;
        $display("FAIL reset_load cyc %0d: got %b want 1", i, load);
      end
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
    n_checks++;
    if (q !== 7'h7F) begin
      n_errors++;
      $display("FAIL release_q: got %h want 7f", q);
    end
    n_checks++;
    if (load !== 1'b0) begin
      n_errors++;
      $display("FAIL release_load: got %b want 0", load);
    end
  endtask

  task automatic test_clock_lane();
    logic [6:0]  pat;
    logic [48:0] d;
    logic [6:0]  exp_q;
    logic        exp_load;
    pat = 7'b1100011;
    d   = '0;
    for (int t = 0; t < 7; t++) d[7*t+6] = pat[6-t];
    align(d);
    for (int i = 0; i < 21; i++) begin
      step();
      exp_q    = {pat[6-(i%7)], 6'b0};
      exp_load = ((i % 7) == 6);
      n_checks++;
      if (q !== exp_q) begin
        n_errors++;
        $display("FAIL clock_lane_q cyc %0d: got %b want %b", i, q, exp_q);
      end
      n_checks++;
      if (load !== exp_load) begin
        n_errors++;
        $display("FAIL clock_lane_load cyc %0d: got %b want %b", i, load, exp_load);
      end
    end
  endtask

  task automatic test_lane_independence();
    logic [48:0] d;
    logic [6:0]  exp_q;
    d = '0;
    d[7*3+2] = 1'b1;
    align(d);
    for (int i = 0; i < 14; i++) begin
      step();
      exp_q = ((i % 7) == 3) ? 7'b0000100 : 7'b0000000;
      n_checks++;
      if (q !== exp_q) begin
        n_errors++;
        $display("FAIL lane_indep cyc %0d: got %b want %b", i, q, exp_q);
      end
    end
  endtask

  task automatic test_load_only();
    logic [6:0] exp_q;
    align('1);
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) din = '0;
      exp_q = (i < 7) ? 7'h7F : 7'h00;
      n_checks++;
      if (q !== exp_q) begin
        n_errors++;
        $display("FAIL load_only cyc %0d: got %h want %h", i, q, exp_q);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_q;
    align('1);
    for (int i = 0; i < 28; i++) begin
      step();
      // Present the following frame right after this frame's load edge.
      if ((i % 7) == 0) din = (((i / 7) + 1) % 2 == 0) ? '1 : '0;
      exp_q = (((i / 7) % 2) == 0) ? 7'h7F : 7'h00;
      n_checks++;
      if (q !== exp_q) begin
        n_errors++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, q, exp_q);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [48:0] a;
    logic [48:0] b;
    logic [6:0]  exp_q;
    logic        exp_load;
    a = 49'h1_5A5A_3C3C_0F0F;
    b = 49'h1_2345_6789_ABCD;
    align(a);
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (q !== a[21 +: 7]) begin
      n_errors++;
      $display("FAIL mid_reset_slot3: got %h want %h", q, a[21 +: 7]);
    end
    // Assert reset between edges: o_q must clear without a clock.
    #2;
    resetn = 1'b0;
    din    = b;
    #1;
    n_checks++;
    if (q !== 7'h00) begin
      n_errors++;
      $display("FAIL mid_reset_async_q: got %h want 00", q);
    end
    n_checks++;
    if (load !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_async_load: got %b want 1", load);
    end
    step();
    step();
    n_checks++;
    if (q !== 7'h00) begin
      n_errors++;
      $display("FAIL mid_reset_held_q: got %h want 00", q);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      exp_q    = b[7*(i%7) +: 7];
      exp_load = ((i % 7) == 6);
      n_checks++;
      if (q !== exp_q) begin
        n_errors++;
        $display("FAIL mid_reset_after_q cyc %0d: got %h want %h", i, q, exp_q);
      end
      n_checks++;
      if (load !== exp_load) begin
        n_errors++;
        $display("FAIL mid_reset_after_load cyc %0d: got %b want %b", i, load, exp_load);
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    din    = '0;
    test_reset();
    test_clock_lane();
    test_lane_independence();
    test_load_only();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gowin_ddr.md
Name: gowin_ddr

Overview:
- 7-lane, 7:1 parallel-to-serial gearbox for the LVDS panel transmit path.
- Each frame, it captures one 49-bit word: 7 bit-slots × 7 lanes, packed time-slot-major.
- It shifts the word out one slot per clock on a 7-bit output bus.
- It sits between the pixel/sync packer and the LVDS output buffers. It issues a load strobe so the packer knows when the next word is sampled.

Parameters:
- LANES, 7, number of serial output lanes (width of o_q).
- RATIO, 7, serialization ratio (bit-slots per frame).
- Din width is LANES*RATIO = 49. Only the defaults need to be supported and verified.

Ports:
- i_clk_fast  input  1  bit/slot clock; all state changes on its rising edge.
- i_resetn  input  1  asynchronous active-low reset.
- din  input  49  parallel frame; din[7*t+k] is lane k's bit for slot t; slot 0 is transmitted first.
- o_load  output  1  high in the cycle whose rising edge samples din (frame boundary).
- o_q  output  7  registered serial lane outputs; o_q[k] = lane k's current slot bit.

Behaviour:
- State:
  - slot counter cnt, 3 bits, range 0..RATIO-1.
  - 49-bit holding register hold.
  - 7-bit output register o_q.
- Reset (i_resetn low, asynchronous, takes effect immediately):
  - cnt = RATIO-1 (6), hold = 0, o_q = 0.
  - o_load therefore reads 1 while in reset.
- Release of reset is synchronous in effect: the first rising edge with i_resetn high is a load edge.
- Each rising edge, when cnt == RATIO-1 (load edge):
  - hold <= din.
  - o_q[k] <= din[k] (slot 0, taken directly from din).
  - cnt <= 0.
- Each rising edge, otherwise:
  - o_q[k] <= hold[7*(cnt+1)+k].
  - cnt <= cnt+1.
- o_load = (cnt == RATIO-1), combinational from cnt. It is high exactly 1 of every 7 cycles.
- Latency: din sampled at edge E appears as:
  - slot 0 on o_q after edge E.
  - slots 1..6 after edges E+1..E+6.
  - The next frame's slot 0 follows immediately after edge E+7. There are no gaps or idle slots.
- din is only sampled on load edges. Changes to din in other cycles have no effect on the frame in flight.
- cnt wraps 6 -> 0 on every load edge. cnt never takes the value 7.
- Reset asserted mid-frame:
  - Aborts the frame immediately.
  - o_q = 0 until the first edge after release.
  - That edge loads a fresh din, with no partial-frame remnants.
- No other output is driven by hold. hold contents are not observable except through o_q.
- The whole design is one clock domain: no DDR primitives and no second clock. The consumer runs i_clk_fast at the serial bit rate.

Test Plan:
- Reset:
  - Stimulus: hold i_resetn low for 5 clocks, with din = all ones.
  - Required response: o_q = 7'b0000000 and o_load = 1 throughout.
  - Release: after the first edge, o_q = 7'b1111111 and o_load = 0.
- Clock-lane pattern:
  - Stimulus: din[7*t+6] = 7'b1100011 bit (6-t) for t=0..6, all other bits 0, held constant.
  - Required response: o_q[6] repeats 1,1,0,0,0,1,1 with period 7; o_q[5:0] stays 0.
  - o_load pulses once per 7 clocks, one cycle before each slot-0 bit.
- Lane independence:
  - Stimulus: din = 1 << (7*3+2), i.e. lane 2, slot 3.
  - Required response: o_q = 7'b0000100 only at frame slot 3; 0 in every other slot.
- Load-only sampling:
  - Stimulus: hold din = A = all ones through the load edge, then set din = 0 during slots 1..6.
  - Required response: slots 1..6 still output 7'b1111111.
  - The next frame outputs 0.
- Back-to-back frames:
  - Stimulus: present alternating words 0x1_FFFF_FFFF_FFFF and 0 at successive load edges.
  - Required response: o_q alternates 7 cycles of 7'h7F and 7 cycles of 7'h00, with no idle cycle between them.
- Mid-frame reset:
  - Stimulus: assert i_resetn low at slot 3 for 2 clocks, then release.
  - Required response: o_q goes to 0 immediately, asynchronously, without waiting for a clock edge.
  - After release: the first edge loads din and outputs slot 0; o_load then pulses every 7 cycles.
